avalon_arbiter2: RTL and testbench

// - Two-host Avalon-MM arbiter sharing the single SDRAM agent port.
// - Host 0: video framebuffer reader. Host 1: image writer/CPU path.
// - Locks the grant for a whole burst: write beats, or read command plus all readdatavalid beats.
// - Sits between the video/writer masters and the avalon_sdram interconnect, all in the sys_clk domain.

---
 rtl/avalon_arbiter2.sv | 168 ++++++++++++++++
 tb/tb_avalon_arbiter2.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_arbiter2.sv
// avalon_arbiter2: two-host Avalon-MM arbiter in front of a single SDRAM agent port.
// Host 0 is the video framebuffer reader. Host 1 is the image writer/CPU path.
// A grant lasts for a whole burst: every write beat, or a read command plus all of its
// readdatavalid beats. Everything runs on the rising edge of sys_clk.
//
// Build option: define ARB_FIXED_PRIO_EN so that host 0 always wins simultaneous requests.
// The default build uses round-robin arbitration, and host 0 wins the first tie after reset.
//
// Ports:
//   sys_clk, sys_rst            clock and synchronous active-high reset
//   hN_address/read/write/      host N (N = 0, 1) command inputs
//   burstcount/writedata/byteenable
//   hN_waitrequest              stall to host N (1 whenever host N is not the granted host)
//   hN_readdata                 agent read data, passed to both hosts
//   hN_readdatavalid            read data valid, sent only to the granted host in the data phase
//   a_*                         agent-side command outputs and response inputs
module avalon_arbiter2 #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter int unsigned BW = 6
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic [AW-1:0]   h0_address,
  input  logic            h0_read,
  input  logic            h0_write,
  input  logic [BW-1:0]   h0_burstcount,
  input  logic [DW-1:0]   h0_writedata,
  input  logic [DW/8-1:0] h0_byteenable,
  output logic            h0_waitrequest,
  output logic [DW-1:0]   h0_readdata,
  output logic            h0_readdatavalid,
  input  logic [AW-1:0]   h1_address,
  input  logic            h1_read,
  input  logic            h1_write,
  input  logic [BW-1:0]   h1_burstcount,
  input  logic [DW-1:0]   h1_writedata,
  input  logic [DW/8-1:0] h1_byteenable,
  output logic            h1_waitrequest,
  output logic [DW-1:0]   h1_readdata,
  output logic            h1_readdatavalid,
  output logic [AW-1:0]   a_address,
  output logic            a_read,
  output logic            a_write,
  output logic [BW-1:0]   a_burstcount,
  output logic [DW-1:0]   a_writedata,
  output logic [DW/8-1:0] a_byteenable,
  input  logic            a_waitrequest,
  input  logic [DW-1:0]   a_readdata,
  input  logic            a_readdatavalid
);

  typedef enum logic [1:0] {StIdle, StWr, StRdCmd, StRdData} state_e;

  localparam logic [BW-1:0] One = {{(BW-1){1'b0}}, 1'b1};

  state_e        state_q;
  logic          gnt_q;
  logic [BW-1:0] cnt_q;
  logic [BW-1:0] blen_q;
`ifndef ARB_FIXED_PRIO_EN
  logic          last_q;
`endif

  logic          req0, req1, win, win_wr;
  logic [BW-1:0] win_bc;
  logic          last_beat;

  always_comb begin
    req0 = h0_read | h0_write;
    req1 = h1_read | h1_write;
`ifdef ARB_FIXED_PRIO_EN
    win = ~req0;
`else
    // On a tie the host that did not own the previous burst wins.
    if (req0 && req1) win = ~last_q;
    else              win = req1;
`endif
    win_bc = win ? h1_burstcount : h0_burstcount;
    win_wr = win ? h1_write : h0_write;
  end

  assign last_beat = (cnt_q == blen_q - One);

  // Command path follows the owner; only read/write/waitrequest/readdatavalid are gated.
  always_comb begin
    a_address        = gnt_q ? h1_address    : h0_address;
    a_burstcount     = gnt_q ? h1_burstcount : h0_burstcount;
    a_writedata      = gnt_q ? h1_writedata  : h0_writedata;
    a_byteenable     = gnt_q ? h1_byteenable : h0_byteenable;
    a_read           = 1'b0;
    a_write          = 1'b0;
    h0_waitrequest   = 1'b1;
    h1_waitrequest   = 1'b1;
    h0_readdatavalid = 1'b0;
    h1_readdatavalid = 1'b0;
    if (!sys_rst) begin
      a_write = (state_q == StWr)    & (gnt_q ? h1_write : h0_write);
      a_read  = (state_q == StRdCmd) & (gnt_q ? h1_read  : h0_read);
      if (state_q != StIdle) begin
        if (gnt_q) h1_waitrequest = a_waitrequest;
        else       h0_waitrequest = a_waitrequest;
      end
      // Valids outside the data phase (e.g. left over from a reset mid-read) are dropped.
      if (state_q == StRdData && a_readdatavalid) begin
        if (gnt_q) h1_readdatavalid = 1'b1;
        else       h0_readdatavalid = 1'b1;
      end
    end
  end

  assign h0_readdata = a_readdata;
  assign h1_readdata = a_readdata;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= StIdle;
      gnt_q   <= 1'b0;
      cnt_q   <= '0;
      blen_q  <= One;
`ifndef ARB_FIXED_PRIO_EN
      last_q  <= 1'b1;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req0 || req1) begin
            gnt_q   <= win;
            blen_q  <= (win_bc == '0) ? One : win_bc;
            cnt_q   <= '0;
            state_q <= win_wr ? StWr : StRdCmd;
          end
        end
        StWr: begin
          if (a_write && !a_waitrequest) begin
            if (last_beat) begin
              cnt_q   <= '0;
`ifndef ARB_FIXED_PRIO_EN
              last_q  <= gnt_q;
`endif
              state_q <= StIdle;
            end else begin
              cnt_q <= cnt_q + One;
            end
          end
        end
        StRdCmd: begin
          if (a_read && !a_waitrequest) state_q <= StRdData;
        end
        StRdData: begin
          if (a_readdatavalid) begin
            if (last_beat) begin
              cnt_q   <= '0;
`ifndef ARB_FIXED_PRIO_EN
              last_q  <= gnt_q;
`endif
              state_q <= StIdle;
            end else begin
              cnt_q <= cnt_q + One;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_arbiter2.sv
// Bench for avalon_arbiter2: host-level transactions with a randomized agent, checked against
// expectations computed from burst lengths, data patterns and the arbitration rule.
module tb_avalon_arbiter2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 6;

  logic            sys_clk = 1'b0;
  logic            sys_rst = 1'b1;
  logic [AW-1:0]   h0_address = '0, h1_address = '0;
  logic            h0_read = 1'b0, h0_write = 1'b0, h1_read = 1'b0, h1_write = 1'b0;
  logic [BW-1:0]   h0_burstcount = '0, h1_burstcount = '0;
  logic [DW-1:0]   h0_writedata = '0, h1_writedata = '0;
  logic [DW/8-1:0] h0_byteenable = '0, h1_byteenable = '0;
  logic            h0_waitrequest, h1_waitrequest, h0_readdatavalid, h1_readdatavalid;
  logic [DW-1:0]   h0_readdata, h1_readdata;
  logic [AW-1:0]   a_address;
  logic            a_read, a_write;
  logic [BW-1:0]   a_burstcount;
  logic [DW-1:0]   a_writedata;
  logic [DW/8-1:0] a_byteenable;
  logic            a_waitrequest = 1'b0;
  logic [DW-1:0]   a_readdata = '0;
  logic            a_readdatavalid = 1'b0;

  avalon_arbiter2 #(.AW(AW), .DW(DW), .BW(BW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .h0_address(h0_address), .h0_read(h0_read), .h0_write(h0_write),
    .h0_burstcount(h0_burstcount), .h0_writedata(h0_writedata), .h0_byteenable(h0_byteenable),
    .h0_waitrequest(h0_waitrequest), .h0_readdata(h0_readdata),
    .h0_readdatavalid(h0_readdatavalid),
    .h1_address(h1_address), .h1_read(h1_read), .h1_write(h1_write),
    .h1_burstcount(h1_burstcount), .h1_writedata(h1_writedata), .h1_byteenable(h1_byteenable),
    .h1_waitrequest(h1_waitrequest), .h1_readdata(h1_readdata),
    .h1_readdatavalid(h1_readdatavalid),
    .a_address(a_address), .a_read(a_read), .a_write(a_write), .a_burstcount(a_burstcount),
    .a_writedata(a_writedata), .a_byteenable(a_byteenable), .a_waitrequest(a_waitrequest),
    .a_readdata(a_readdata), .a_readdatavalid(a_readdatavalid)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail = 0;

  // Observations of the most recent transaction.
  logic [DW-1:0] seen_data[$];
  logic [DW-1:0] exp_data[$];
  int            seen_host[$];
  int            rdv_cnt[2];
  int            bubbles, other_low, aread_in_data, timed_out;
  logic [BW-1:0] seen_bc;
  logic          post_wait, post_cmd;

  function automatic logic host_wait(input int h);
    return (h == 0) ? h0_waitrequest : h1_waitrequest;
  endfunction

  function automatic logic host_rdv(input int h);
    return (h == 0) ? h0_readdatavalid : h1_readdatavalid;
  endfunction

  function automatic logic [DW-1:0] host_rdata(input int h);
    return (h == 0) ? h0_readdata : h1_readdata;
  endfunction

  // Address MSB tags the issuing host so the agent side can tell who owns a command.
  function automatic logic [AW-1:0] make_addr(input int h);
    logic [AW-1:0] a;
    a = AW'($urandom);
    a[AW-1] = h[0];
    return a;
  endfunction

  function automatic int data_errors();
    int bad = 0;
    foreach (seen_data[i]) if (i >= exp_data.size() || seen_data[i] !== exp_data[i]) bad++;
    return bad;
  endfunction

  function automatic int host_errors(input int h);
    int bad = 0;
    foreach (seen_host[i]) if (seen_host[i] != h) bad++;
    return bad;
  endfunction

  task automatic set_host(input int h, input logic rd, input logic wr, input logic [AW-1:0] ad,
                          input logic [BW-1:0] bc, input logic [DW-1:0] wd);
    if (h == 0) begin
      h0_read = rd; h0_write = wr; h0_address = ad; h0_burstcount = bc; h0_writedata = wd;
      h0_byteenable = '1;
    end else begin
      h1_read = rd; h1_write = wr; h1_address = ad; h1_burstcount = bc; h1_writedata = wd;
      h1_byteenable = '1;
    end
  endtask

  task automatic clear_obs();
    seen_data.delete(); exp_data.delete(); seen_host.delete();
    rdv_cnt[0] = 0; rdv_cnt[1] = 0;
    bubbles = 0; other_low = 0; aread_in_data = 0; timed_out = 0; seen_bc = '0;
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    set_host(0, 1'b0, 1'b0, '0, '0, '0);
    set_host(1, 1'b0, 1'b0, '0, '0, '0);
    a_waitrequest = 1'b0; a_readdatavalid = 1'b0;
    @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  // One cycle with every host idle; records whether host h is back to waitrequest=1.
  task automatic post_idle(input int h);
    @(negedge sys_clk);
    set_host(h, 1'b0, 1'b0, '0, '0, '0);
    a_waitrequest = 1'b0; a_readdatavalid = 1'b0;
    #1;
    post_wait = host_wait(h);
    post_cmd  = a_read | a_write;
  endtask

  // Host h writes a burst; the agent stalls stall_len cycles on beat index stall_at.
  task automatic run_write(input int h, input logic [BW-1:0] bc, input int stall_at,
                           input int stall_len, input bit rnd_wait);
    int            nbeats = (bc == 0) ? 1 : int'(bc);
    int            sent = 0;
    int            stall_left = stall_len;
    int            cyc = 0;
    logic [DW-1:0] base = $urandom;
    logic [AW-1:0] addr = make_addr(h);
    clear_obs();
    for (int i = 0; i < nbeats; i++) exp_data.push_back(base + DW'(i));
    while (sent < nbeats && cyc < 400) begin
      @(negedge sys_clk);
      cyc++;
      set_host(h, 1'b0, 1'b1, addr, bc, base + DW'(sent));
      a_waitrequest = 1'b0;
      #1;
      if (a_write && sent == stall_at && stall_left > 0) begin
        a_waitrequest = 1'b1;
        stall_left--;
      end else if (rnd_wait) begin
        a_waitrequest = ($urandom_range(3) == 0);
      end
      #1;
      if (!a_write) bubbles++;
      if (a_write && !a_waitrequest) begin
        seen_data.push_back(a_writedata);
        seen_host.push_back(int'(a_address[AW-1]));
      end
      if (!host_wait(1 - h)) other_low++;
      if (!host_wait(h)) sent++;
    end
    timed_out = (sent < nbeats) ? 1 : 0;
  endtask

  // Host h reads a burst; the agent returns ret beats with random gaps.
  task automatic run_read(input int h, input logic [BW-1:0] bc, input int ret);
    int            got = 0;
    int            cyc = 0;
    bit            cmd_done = 1'b0;
    logic [DW-1:0] base = $urandom;
    logic [AW-1:0] addr = make_addr(h);
    clear_obs();
    for (int i = 0; i < ret; i++) exp_data.push_back(base + DW'(i));
    while (!cmd_done && cyc < 400) begin
      @(negedge sys_clk);
      cyc++;
      set_host(h, 1'b1, 1'b0, addr, bc, DW'($urandom));
      a_readdatavalid = 1'b0;
      a_waitrequest = ($urandom_range(3) == 0);
      #1;
      if (!a_read) bubbles++;
      if (a_read && !a_waitrequest) begin
        seen_host.push_back(int'(a_address[AW-1]));
        seen_bc = a_burstcount;
      end
      if (!host_wait(1 - h)) other_low++;
      if (!host_wait(h)) cmd_done = 1'b1;
    end
    while (got < ret && cyc < 800) begin
      @(negedge sys_clk);
      cyc++;
      set_host(h, 1'b0, 1'b0, addr, bc, '0);
      a_waitrequest = ($urandom_range(1) == 0);
      a_readdatavalid = ($urandom_range(2) != 0);
      a_readdata = base + DW'(got);
      #1;
      if (a_read) aread_in_data++;
      rdv_cnt[0] += int'(h0_readdatavalid);
      rdv_cnt[1] += int'(h1_readdatavalid);
      if (host_rdv(h)) seen_data.push_back(host_rdata(h));
      if (!host_wait(1 - h)) other_low++;
      if (a_readdatavalid) got++;
    end
    timed_out = (!cmd_done || got < ret) ? 1 : 0;
  endtask

  task automatic test_reset();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    set_host(0, 1'b1, 1'b0, make_addr(0), 6'd4, '0);
    set_host(1, 1'b0, 1'b1, make_addr(1), 6'd4, '0);
    a_readdatavalid = 1'b1;
    @(negedge sys_clk);
    #1;
    n_checks++;
    if ({a_read, a_write} !== 2'b00) begin
      n_fail++; $display("FAIL reset_cmd: a_read/a_write=%b want 00", {a_read, a_write});
    end
    n_checks++;
    if ({h0_waitrequest, h1_waitrequest} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_wait: got %b want 11", {h0_waitrequest, h1_waitrequest});
    end
    n_checks++;
    if ({h0_readdatavalid, h1_readdatavalid} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_rdv: got %b want 00", {h0_readdatavalid, h1_readdatavalid});
    end
    // Reset while a write burst is stalled at the agent.
    do_reset();
    set_host(1, 1'b0, 1'b1, make_addr(1), 6'd4, '0);
    a_waitrequest = 1'b1;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    #1;
    n_checks++;
    if (a_write !== 1'b0 || h1_waitrequest !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_midwrite: a_write=%b h1_wait=%b want 0 1", a_write, h1_waitrequest);
    end
    do_reset();
  endtask

  task automatic test_write_stall();
    run_write(1, 6'd4, 1, 2, 1'b0);
    post_idle(1);
    n_checks++;
    if (seen_data.size() != 4 || timed_out != 0) begin
      n_fail++; $display("FAIL t1_beats: got %0d beats want 4", seen_data.size());
    end
    n_checks++;
    if (data_errors() != 0 || host_errors(1) != 0) begin
      n_fail++;
      $display("FAIL t1_data: %0d bad data, %0d bad owner, want 0", data_errors(), host_errors(1));
    end
    n_checks++;
    if (other_low != 0) begin
      n_fail++; $display("FAIL t1_h0_wait: h0_waitrequest low %0d cycles want 0", other_low);
    end
    n_checks++;
    if (bubbles != 1 || post_wait !== 1'b1) begin
      n_fail++; $display("FAIL t1_grant: bubbles=%0d post_wait=%b want 1 1", bubbles, post_wait);
    end
  endtask

  task automatic test_read_burst(input int h, input logic [BW-1:0] bc, input string tag);
    run_read(h, bc, int'(bc));
    post_idle(h);
    n_checks++;
    if (rdv_cnt[h] != int'(bc) || rdv_cnt[1 - h] != 0 || timed_out != 0) begin
      n_fail++;
      $display("FAIL %s_rdv: owner=%0d other=%0d want %0d 0", tag, rdv_cnt[h], rdv_cnt[1 - h],
               bc);
    end
    n_checks++;
    if (data_errors() != 0 || seen_data.size() != int'(bc)) begin
      n_fail++; $display("FAIL %s_data: %0d bad of %0d want 0", tag, data_errors(), bc);
    end
    n_checks++;
    if (seen_bc !== bc || seen_host.size() != 1 || host_errors(h) != 0) begin
      n_fail++; $display("FAIL %s_cmd: burstcount=%0d cmds=%0d want %0d 1", tag, seen_bc,
                         seen_host.size(), bc);
    end
    n_checks++;
    if (aread_in_data != 0 || bubbles != 1) begin
      n_fail++; $display("FAIL %s_aread: a_read in data %0d, bubbles %0d want 0 1", tag,
                         aread_in_data, bubbles);
    end
    n_checks++;
    if (post_wait !== 1'b1 || post_cmd !== 1'b0) begin
      n_fail++; $display("FAIL %s_idle: wait=%b cmd=%b want 1 0", tag, post_wait, post_cmd);
    end
  endtask

  task automatic test_arbitration();
    int want[2];
    int done[2];
    int pending = 0;
    int cyc = 0;
    int grants[$];
    int exp_g[4];
`ifdef ARB_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    do_reset();
    want = '{1, 1};
    done = '{0, 0};
    while ((done[0] < 4 || done[1] < 4) && cyc < 600) begin
      @(negedge sys_clk);
      cyc++;
      for (int h = 0; h < 2; h++) set_host(h, want[h] != 0, 1'b0, make_addr(h), 6'd1, '0);
      a_waitrequest = ($urandom_range(3) == 0);
      a_readdatavalid = (pending > 0) && ($urandom_range(1) == 1);
      a_readdata = $urandom;
      #1;
      if (a_read && !a_waitrequest) begin
        grants.push_back(int'(a_address[AW-1]));
        pending++;
      end
      if (a_readdatavalid) pending--;
      for (int h = 0; h < 2; h++) begin
        if (want[h] != 0 && !host_wait(h)) want[h] = 0;
        if (host_rdv(h)) begin
          done[h]++;
          if (done[h] < 4) want[h] = 1;
        end
      end
    end
    post_idle(0);
    post_idle(1);
    n_checks++;
    if (grants.size() != 8 || done[0] != 4 || done[1] != 4) begin
      n_fail++; $display("FAIL t3_count: grants=%0d done=%0d/%0d want 8 4/4", grants.size(),
                         done[0], done[1]);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= grants.size() || grants[i] != exp_g[i]) begin
        n_fail++; $display("FAIL t3_order[%0d]: got %0d want %0d", i,
                           (i < grants.size()) ? grants[i] : -1, exp_g[i]);
      end
    end
  endtask

  task automatic test_zero_burst();
    run_write(0, 6'd0, -1, 0, 1'b1);
    post_idle(0);
    n_checks++;
    if (seen_data.size() != 1 || data_errors() != 0 || timed_out != 0) begin
      n_fail++; $display("FAIL t4_beats: got %0d beats want 1", seen_data.size());
    end
    n_checks++;
    if (post_wait !== 1'b1 || bubbles != 1) begin
      n_fail++; $display("FAIL t4_idle: post_wait=%b bubbles=%0d want 1 1", post_wait, bubbles);
    end
  endtask

  task automatic test_reset_mid_read();
    int r0 = 0;
    int r1 = 0;
    run_read(0, 6'd8, 3);
    n_checks++;
    if (rdv_cnt[0] != 3 || timed_out != 0) begin
      n_fail++; $display("FAIL t5_pre: h0 valids %0d want 3", rdv_cnt[0]);
    end
    @(negedge sys_clk);
    sys_rst = 1'b1;
    a_readdatavalid = 1'b0;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge sys_clk);
      a_readdatavalid = 1'b1;
      a_readdata = $urandom;
      #1;
      r0 += int'(h0_readdatavalid);
      r1 += int'(h1_readdatavalid);
    end
    @(negedge sys_clk);
    a_readdatavalid = 1'b0;
    n_checks++;
    if (r0 != 0 || r1 != 0) begin
      n_fail++; $display("FAIL t5_stray: h0=%0d h1=%0d valids want 0 0", r0, r1);
    end
    run_write(1, 6'd4, -1, 0, 1'b1);
    post_idle(1);
    n_checks++;
    if (seen_data.size() != 4 || data_errors() != 0 || bubbles != 1 || post_wait !== 1'b1) begin
      n_fail++; $display("FAIL t5_next: beats=%0d bubbles=%0d want 4 1", seen_data.size(),
                         bubbles);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 10; t++) begin
      int            h = int'($urandom_range(1));
      bit            wr = 1'($urandom_range(1));
      logic [BW-1:0] bc = BW'($urandom_range(32));
      int            nb = (bc == 0) ? 1 : int'(bc);
      if (wr) run_write(h, bc, int'($urandom_range(3)), int'($urandom_range(2)), 1'b1);
      else    run_read(h, bc, nb);
      post_idle(h);
      n_checks++;
      if (seen_data.size() != nb || data_errors() != 0 || timed_out != 0) begin
        n_fail++; $display("FAIL rnd%0d_data: wr=%0d beats=%0d bad=%0d want %0d 0", t, wr,
                           seen_data.size(), data_errors(), nb);
      end
      n_checks++;
      if (host_errors(h) != 0 || other_low != 0 || rdv_cnt[1 - h] != 0) begin
        n_fail++; $display("FAIL rnd%0d_owner: bad=%0d other_low=%0d other_rdv=%0d want 0", t,
                           host_errors(h), other_low, rdv_cnt[1 - h]);
      end
      n_checks++;
      if (bubbles != 1 || post_wait !== 1'b1) begin
        n_fail++; $display("FAIL rnd%0d_idle: bubbles=%0d post_wait=%b want 1 1", t, bubbles,
                           post_wait);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_stall();
    test_read_burst(0, 6'd8, "t2");
    test_arbitration();
    test_zero_burst();
    test_reset_mid_read();
    test_read_burst(0, 6'd32, "t6");
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
